// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer widths and entry type encodings, also used by the register file.
package reorder_buffer_pkg;
  localparam int ROB_W    = 3;
  localparam int ROB_SIZE = 1 << ROB_W;
  localparam int REG_W    = 5;

  typedef enum logic [1:0] {
    ENTRY_REG    = 2'd0,
    ENTRY_STORE  = 2'd1,
    ENTRY_BRANCH = 2'd2
  } entry_type_e;

  function automatic entry_type_e entry_type(input logic is_branch, input logic is_store);
    if (is_branch) begin
      return ENTRY_BRANCH;
    end else if (is_store) begin
      return ENTRY_STORE;
    end else begin
      return ENTRY_REG;
    end
  endfunction
endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at the tail, captures CDB results, retires in order
// from the head, forwards operands combinationally and raises a flush on a mispredicted head branch.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_W,
  parameter int REG_WIDTH = REG_W
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_valid,
  input  logic [REG_WIDTH-1:0] issue_reg_id,
  input  logic                 issue_is_branch,
  input  logic                 issue_is_store,
  output logic                 issue_ready,
  output logic [ROB_WIDTH-1:0] issue_rob_id,
  input  logic                 cdb_valid,
  input  logic [ROB_WIDTH-1:0] cdb_rob_id,
  input  logic [31:0]          cdb_data,
  input  logic                 cdb_mispredict,
  input  logic [31:0]          cdb_target,
  input  logic [ROB_WIDTH-1:0] rob_rob_id_j,
  input  logic [ROB_WIDTH-1:0] rob_rob_id_k,
  output logic                 rob_ready_j,
  output logic                 rob_ready_k,
  output logic [31:0]          rob_data_j,
  output logic [31:0]          rob_data_k,
  output logic [REG_WIDTH-1:0] commit_reg_id,
  output logic [31:0]          commit_data,
  output logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic                 commit_store,
  output logic                 flush,
  output logic [31:0]          flush_pc
);
  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] DEPTH_CNT = (ROB_WIDTH + 1)'(DEPTH);

  logic [DEPTH-1:0]     r_busy;
  logic [DEPTH-1:0]     r_ready;
  entry_type_e          r_type [DEPTH];
  logic [REG_WIDTH-1:0] r_reg [DEPTH];
  logic [31:0]          r_data [DEPTH];
  logic                 r_mispredict [DEPTH];
  logic [31:0]          r_target [DEPTH];
  logic [ROB_WIDTH-1:0] r_head;
  logic [ROB_WIDTH-1:0] r_tail;
  logic [ROB_WIDTH:0]   r_count;
  logic [REG_WIDTH-1:0] r_commit_reg_id;
  logic [31:0]          r_commit_data;
  logic [ROB_WIDTH-1:0] r_commit_rob_id;
  logic                 r_commit_store;
  logic                 r_flush;
  logic [31:0]          r_flush_pc;

  logic w_issue_ready, w_issue_fire, w_cdb_hit;
  logic w_head_done, w_head_flush, w_commit;
  logic w_fwd_j, w_fwd_k;

  // Slot availability uses registered count only, so a same-cycle commit never frees a slot.
  assign w_issue_ready = (r_count < DEPTH_CNT) && !r_flush;
  assign w_issue_fire  = issue_valid && w_issue_ready;
  assign w_cdb_hit     = cdb_valid && r_busy[cdb_rob_id];
  assign w_head_done   = (r_count != '0) && r_busy[r_head] && r_ready[r_head];
  assign w_head_flush  = w_head_done && (r_type[r_head] == ENTRY_BRANCH) && r_mispredict[r_head];
  assign w_commit      = w_head_done && !w_head_flush;
  assign w_fwd_j       = cdb_valid && (cdb_rob_id == rob_rob_id_j);
  assign w_fwd_k       = cdb_valid && (cdb_rob_id == rob_rob_id_k);

  assign issue_ready   = w_issue_ready;
  assign issue_rob_id  = r_tail;
  assign rob_ready_j   = r_ready[rob_rob_id_j] || w_fwd_j;
  assign rob_ready_k   = r_ready[rob_rob_id_k] || w_fwd_k;
  assign rob_data_j    = w_fwd_j ? cdb_data : r_data[rob_rob_id_j];
  assign rob_data_k    = w_fwd_k ? cdb_data : r_data[rob_rob_id_k];
  assign commit_reg_id = r_commit_reg_id;
  assign commit_data   = r_commit_data;
  assign commit_rob_id = r_commit_rob_id;
  assign commit_store  = r_commit_store;
  assign flush         = r_flush;
  assign flush_pc      = r_flush_pc;

  // Entry payload: validity is guarded by the busy/ready bits, so no reset is needed here.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !r_flush) begin
      if (w_issue_fire) begin
        r_type[r_tail] <= entry_type(issue_is_branch, issue_is_store);
        r_reg[r_tail]  <= issue_reg_id;
      end
      if (w_cdb_hit) begin
        r_data[cdb_rob_id]       <= cdb_data;
        r_mispredict[cdb_rob_id] <= cdb_mispredict;
        r_target[cdb_rob_id]     <= cdb_target;
      end
    end
  end

  // Pointers, entry status bits and the registered commit/flush outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy          <= '0;
      r_ready         <= '0;
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_commit_reg_id <= '0;
      r_commit_data   <= 32'd0;
      r_commit_rob_id <= '0;
      r_commit_store  <= 1'b0;
      r_flush         <= 1'b0;
      r_flush_pc      <= 32'd0;
    end else if (rdy_in) begin
      r_commit_reg_id <= '0;
      r_commit_store  <= 1'b0;
      r_flush         <= 1'b0;
      if (r_flush) begin
        r_busy  <= '0;
        r_ready <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_issue_fire) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= 1'b0;
          r_tail          <= r_tail + 1'b1;
        end
        if (w_cdb_hit) begin
          r_ready[cdb_rob_id] <= 1'b1;
        end
        if (w_head_flush) begin
          r_flush    <= 1'b1;
          r_flush_pc <= r_target[r_head];
        end else if (w_commit) begin
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + 1'b1;
          r_commit_data   <= r_data[r_head];
          r_commit_rob_id <= r_head;
          if (r_type[r_head] == ENTRY_STORE) begin
            r_commit_store <= 1'b1;
          end else begin
            r_commit_reg_id <= r_reg[r_head];
          end
        end
        case ({w_issue_fire, w_commit})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_reorder_buffer;
  localparam int DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, issue_valid, issue_is_branch, issue_is_store, issue_ready;
  logic [4:0]  issue_reg_id, commit_reg_id;
  logic [2:0]  issue_rob_id, cdb_rob_id, rob_rob_id_j, rob_rob_id_k, commit_rob_id;
  logic        cdb_valid, cdb_mispredict, rob_ready_j, rob_ready_k, commit_store, flush;
  logic [31:0] cdb_data, cdb_target, rob_data_j, rob_data_k, commit_data, flush_pc;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          id;
    int          rg;
    bit          st;
    bit          br;
    bit          done;
    logic [31:0] data;
    bit          misp;
    logic [31:0] tgt;
  } ent_t;
  ent_t q[$];
  int   m_tail;
  bit   m_flush;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_reg_id(issue_reg_id), .issue_is_branch(issue_is_branch),
    .issue_is_store(issue_is_store), .issue_ready(issue_ready), .issue_rob_id(issue_rob_id),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .rob_rob_id_j(rob_rob_id_j), .rob_rob_id_k(rob_rob_id_k),
    .rob_ready_j(rob_ready_j), .rob_ready_k(rob_ready_k),
    .rob_data_j(rob_data_j), .rob_data_k(rob_data_k),
    .commit_reg_id(commit_reg_id), .commit_data(commit_data), .commit_rob_id(commit_rob_id),
    .commit_store(commit_store), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1; issue_valid = 1'b0; issue_reg_id = 5'd0; issue_is_branch = 1'b0;
    issue_is_store = 1'b0; cdb_valid = 1'b0; cdb_rob_id = 3'd0; cdb_data = 32'd0;
    cdb_mispredict = 1'b0; cdb_target = 32'd0; rob_rob_id_j = 3'd0; rob_rob_id_k = 3'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b1;
    #3;
    rst_in = 1'b0;
    tick();
  endtask

  task automatic issue(input logic [4:0] rg, input logic br, input logic st);
    issue_valid = 1'b1; issue_reg_id = rg; issue_is_branch = br; issue_is_store = st;
    tick();
    issue_valid = 1'b0; issue_is_branch = 1'b0; issue_is_store = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] id, input logic [31:0] d, input logic mp, input logic [31:0] tg);
    cdb_valid = 1'b1; cdb_rob_id = id; cdb_data = d; cdb_mispredict = mp; cdb_target = tg;
    tick();
    cdb_valid = 1'b0; cdb_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    issue(5'd1, 1'b0, 1'b0); issue(5'd2, 1'b0, 1'b0); issue(5'd3, 1'b0, 1'b0);
    do_reset();
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_issue_ready got=%0b exp=1", issue_ready); end
    total++; if (issue_rob_id !== 3'd0) begin bad++; $display("FAIL reset_issue_rob_id got=%0d exp=0", issue_rob_id); end
    total++; if (commit_reg_id !== 5'd0) begin bad++; $display("FAIL reset_commit_reg got=%0d exp=0", commit_reg_id); end
    total++; if (flush !== 1'b0 || flush_pc !== 32'd0) begin bad++; $display("FAIL reset_flush got=%0b/%0h exp=0/0", flush, flush_pc); end
    total++; if (rob_ready_j !== 1'b0) begin bad++; $display("FAIL reset_entry_dropped got=%0b exp=0", rob_ready_j); end
  endtask

  task automatic test_in_order();
    do_reset();
    issue(5'd5, 1'b0, 1'b0); issue(5'd6, 1'b0, 1'b0);
    cdb(3'd1, 32'h22, 1'b0, 32'd0);
    cdb(3'd0, 32'h11, 1'b0, 32'd0);
    total++; if (commit_reg_id !== 5'd0) begin bad++; $display("FAIL order_same_cycle got=%0d exp=0", commit_reg_id); end
    tick();
    total++; if ({commit_reg_id, commit_data, commit_rob_id, commit_store} !== {5'd5, 32'h11, 3'd0, 1'b0}) begin
      bad++; $display("FAIL order_first got=%0d/%0h/%0d exp=5/11/0", commit_reg_id, commit_data, commit_rob_id); end
    tick();
    total++; if ({commit_reg_id, commit_data, commit_rob_id} !== {5'd6, 32'h22, 3'd1}) begin
      bad++; $display("FAIL order_second got=%0d/%0h/%0d exp=6/22/1", commit_reg_id, commit_data, commit_rob_id); end
    tick();
    total++; if (commit_reg_id !== 5'd0) begin bad++; $display("FAIL order_empty got=%0d exp=0", commit_reg_id); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < DEPTH; i++) issue(5'(i + 1), 1'b0, 1'b0);
    issue_valid = 1'b1; issue_reg_id = 5'd9;
    #1;
    total++; if (issue_ready !== 1'b0 || issue_rob_id !== 3'd0) begin
      bad++; $display("FAIL full_ready got=%0b/%0d exp=0/0", issue_ready, issue_rob_id); end
    tick();
    issue_valid = 1'b0;
    total++; if (issue_ready !== 1'b0 || issue_rob_id !== 3'd0) begin
      bad++; $display("FAIL full_ninth_ignored got=%0b/%0d exp=0/0", issue_ready, issue_rob_id); end
    cdb(3'd0, 32'hA0, 1'b0, 32'd0);
    tick();
    total++; if (commit_reg_id !== 5'd1 || commit_rob_id !== 3'd0) begin
      bad++; $display("FAIL full_commit got=%0d/%0d exp=1/0", commit_reg_id, commit_rob_id); end
    total++; if (issue_ready !== 1'b1 || issue_rob_id !== 3'd0) begin
      bad++; $display("FAIL full_slot_freed got=%0b/%0d exp=1/0", issue_ready, issue_rob_id); end
    issue(5'd10, 1'b0, 1'b0);
    total++; if (issue_ready !== 1'b0 || issue_rob_id !== 3'd1) begin
      bad++; $display("FAIL full_wrapped got=%0b/%0d exp=0/1", issue_ready, issue_rob_id); end
  endtask

  task automatic test_forward();
    rob_rob_id_j = 3'd3; rob_rob_id_k = 3'd4;
    cdb_valid = 1'b1; cdb_rob_id = 3'd3; cdb_data = 32'hDEAD;
    #1;
    total++; if (rob_ready_j !== 1'b1 || rob_data_j !== 32'hDEAD) begin
      bad++; $display("FAIL fwd_same_cycle got=%0b/%0h exp=1/dead", rob_ready_j, rob_data_j); end
    total++; if (rob_ready_k !== 1'b0) begin bad++; $display("FAIL fwd_other got=%0b exp=0", rob_ready_k); end
    tick();
    cdb_valid = 1'b0;
    #1;
    total++; if (rob_ready_j !== 1'b1 || rob_data_j !== 32'hDEAD) begin
      bad++; $display("FAIL fwd_stored got=%0b/%0h exp=1/dead", rob_ready_j, rob_data_j); end
  endtask

  task automatic test_flush();
    do_reset();
    issue(5'd0, 1'b1, 1'b0); issue(5'd7, 1'b0, 1'b0); issue(5'd8, 1'b0, 1'b0);
    cdb(3'd1, 32'h77, 1'b0, 32'd0);
    cdb(3'd2, 32'h88, 1'b0, 32'd0);
    cdb(3'd0, 32'h0, 1'b1, 32'h100);
    tick();
    total++; if (flush !== 1'b1 || flush_pc !== 32'h100) begin
      bad++; $display("FAIL flush_pulse got=%0b/%0h exp=1/100", flush, flush_pc); end
    total++; if (issue_ready !== 1'b0 || commit_reg_id !== 5'd0) begin
      bad++; $display("FAIL flush_blocks got=%0b/%0d exp=0/0", issue_ready, commit_reg_id); end
    tick();
    total++; if (flush !== 1'b0 || issue_ready !== 1'b1 || issue_rob_id !== 3'd0) begin
      bad++; $display("FAIL flush_cleared got=%0b/%0b/%0d exp=0/1/0", flush, issue_ready, issue_rob_id); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (commit_reg_id !== 5'd0) begin bad++; $display("FAIL flush_no_young_commit got=%0d exp=0", commit_reg_id); end
    end
  endtask

  task automatic test_rdy_hold();
    do_reset();
    issue(5'd9, 1'b0, 1'b0);
    cdb(3'd0, 32'h55, 1'b0, 32'd0);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (commit_reg_id !== 5'd0) begin bad++; $display("FAIL rdy_hold got=%0d exp=0", commit_reg_id); end
    end
    rdy_in = 1'b1;
    tick();
    total++; if (commit_reg_id !== 5'd9 || commit_data !== 32'h55) begin
      bad++; $display("FAIL rdy_resume got=%0d/%0h exp=9/55", commit_reg_id, commit_data); end
  endtask

  function automatic void model_lookup(input logic [2:0] id, output bit rdy, output logic [31:0] d);
    rdy = 1'b0; d = 32'd0;
    foreach (q[i]) if (q[i].id == int'(id) && q[i].done) begin rdy = 1'b1; d = q[i].data; end
    if (cdb_valid && cdb_rob_id == id) begin rdy = 1'b1; d = cdb_data; end
  endfunction

  task automatic test_random(input int n);
    bit          accept, comm, exp_f, exp_st, er;
    int          exp_reg, exp_id;
    logic [31:0] exp_d, exp_pc, ed;
    ent_t        e;
    do_reset();
    q.delete(); m_tail = 0; m_flush = 1'b0;
    comm = 1'b0; exp_f = 1'b0; exp_st = 1'b0; exp_reg = 0; exp_id = 0; exp_d = 32'd0; exp_pc = 32'd0;
    for (int c = 0; c < n; c++) begin
      rdy_in          = ($urandom_range(0, 9) != 0);
      issue_valid     = $urandom_range(0, 1) != 0;
      issue_reg_id    = 5'($urandom);
      issue_is_branch = ($urandom_range(0, 3) == 0);
      issue_is_store  = !issue_is_branch && ($urandom_range(0, 3) == 0);
      cdb_valid       = ($urandom_range(0, 2) != 0);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) cdb_rob_id = 3'(q[$urandom_range(0, q.size() - 1)].id);
      else cdb_rob_id = 3'($urandom);
      cdb_data = $urandom; cdb_mispredict = ($urandom_range(0, 3) == 0); cdb_target = $urandom;
      rob_rob_id_j = 3'($urandom); rob_rob_id_k = 3'($urandom);
      #1;
      total++; if (issue_ready !== (q.size() < DEPTH && !m_flush)) begin
        bad++; $display("FAIL rnd_issue_ready cyc=%0d got=%0b q=%0d fl=%0b", c, issue_ready, q.size(), m_flush); end
      total++; if (issue_rob_id !== 3'(m_tail)) begin
        bad++; $display("FAIL rnd_issue_rob_id cyc=%0d got=%0d exp=%0d", c, issue_rob_id, m_tail); end
      model_lookup(rob_rob_id_j, er, ed);
      total++; if (rob_ready_j !== er || (er && rob_data_j !== ed)) begin
        bad++; $display("FAIL rnd_lookup_j cyc=%0d got=%0b/%0h exp=%0b/%0h", c, rob_ready_j, rob_data_j, er, ed); end
      model_lookup(rob_rob_id_k, er, ed);
      total++; if (rob_ready_k !== er || (er && rob_data_k !== ed)) begin
        bad++; $display("FAIL rnd_lookup_k cyc=%0d got=%0b/%0h exp=%0b/%0h", c, rob_ready_k, rob_data_k, er, ed); end
      if (rdy_in) begin
        comm = 1'b0; exp_f = 1'b0; exp_st = 1'b0; exp_reg = 0;
        if (m_flush) begin
          q.delete(); m_tail = 0; m_flush = 1'b0;
        end else begin
          accept = issue_valid && (q.size() < DEPTH);
          if (q.size() > 0 && q[0].done) begin
            if (q[0].br && q[0].misp) begin
              exp_f = 1'b1; exp_pc = q[0].tgt; m_flush = 1'b1;
            end else begin
              comm = 1'b1; exp_d = q[0].data; exp_id = q[0].id; exp_st = q[0].st;
              exp_reg = q[0].st ? 0 : q[0].rg;
              void'(q.pop_front());
            end
          end
          if (cdb_valid) foreach (q[i]) if (q[i].id == int'(cdb_rob_id)) begin
            q[i].done = 1'b1; q[i].data = cdb_data; q[i].misp = cdb_mispredict; q[i].tgt = cdb_target;
          end
          if (accept) begin
            e.id = m_tail; e.rg = int'(issue_reg_id); e.st = issue_is_store; e.br = issue_is_branch;
            e.done = 1'b0; e.data = 32'd0; e.misp = 1'b0; e.tgt = 32'd0;
            q.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
          end
        end
      end
      tick();
      total++; if (commit_reg_id !== 5'(exp_reg) || commit_store !== exp_st || flush !== exp_f) begin
        bad++; $display("FAIL rnd_commit cyc=%0d got=%0d/%0b/%0b exp=%0d/%0b/%0b", c, commit_reg_id, commit_store, flush, exp_reg, exp_st, exp_f); end
      if (comm) begin
        total++; if (commit_data !== exp_d || commit_rob_id !== 3'(exp_id)) begin
          bad++; $display("FAIL rnd_commit_data cyc=%0d got=%0h/%0d exp=%0h/%0d", c, commit_data, commit_rob_id, exp_d, exp_id); end
      end
      if (exp_f) begin
        total++; if (flush_pc !== exp_pc) begin bad++; $display("FAIL rnd_flush_pc cyc=%0d got=%0h exp=%0h", c, flush_pc, exp_pc); end
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    tick();
    test_reset();
    test_in_order();
    test_full_wrap();
    test_forward();
    test_flush();
    test_rdy_hold();
    test_random(600);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
